// File: rtl/design_exmpl_host_rtl_if.sv
// Request/response handshake bundle between a run requester and the design-example host.
interface design_exmpl_host_rtl_if;
    logic       req_valid_i;
    logic       req_ready_o;
    logic       rsp_valid_o;
    logic       rsp_ready_i;
    logic [3:0] rsp_A_o4;
    logic       rsp_E_o;
    logic       rsp_tmo_o;

    modport master (
        output req_valid_i, rsp_ready_i,
        input  req_ready_o, rsp_valid_o, rsp_A_o4, rsp_E_o, rsp_tmo_o
    );

    modport slave (
        input  req_valid_i, rsp_ready_i,
        output req_ready_o, rsp_valid_o, rsp_A_o4, rsp_E_o, rsp_tmo_o
    );
endinterface

// File: rtl/design_exmpl_host_rtl.sv
// Runs one start/F transaction on the design example and returns A/E (or a watchdog abort).
// Latency: response 15 cycles after start_o with the real example; result held until rsp_ready_i.
module design_exmpl_host_rtl #(
    parameter int TIMEOUT_CYCLES = 32
) (
    input  logic                       clk_i,
    input  logic                       rst_i,
    design_exmpl_host_rtl_if.slave     host,
    output logic                       start_o,
    input  logic [3:0]                 A_i4,
    input  logic                       E_i,
    input  logic                       F_i,
    output logic                       busy_o
);

    localparam int CW = $clog2(TIMEOUT_CYCLES) + 1;

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        START     = 3'd1,
        WAIT_CLR  = 3'd2,
        WAIT_DONE = 3'd3,
        RESP      = 3'd4
    } state_t;

    state_t          state;
    state_t          next_state;
    logic [CW-1:0]   count;
    logic            in_wait;
    logic            tmo_hit;
    logic            done_ok;
    logic            capture;

    assign in_wait = (state == WAIT_CLR) || (state == WAIT_DONE);
    assign tmo_hit = (count == CW'(TIMEOUT_CYCLES - 1));
    assign done_ok = (state == WAIT_DONE) && F_i;
    assign capture = in_wait && (next_state == RESP);

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // A normal exit is tested before the watchdog so it wins on the last budget cycle.
    always_comb begin
        next_state = state;
        case (state)
            IDLE:      if (host.req_valid_i) next_state = START;
            START:     next_state = WAIT_CLR;
            WAIT_CLR:  begin
                if (!F_i)         next_state = WAIT_DONE;
                else if (tmo_hit) next_state = RESP;
            end
            WAIT_DONE: begin
                if (F_i)          next_state = RESP;
                else if (tmo_hit) next_state = RESP;
            end
            RESP:      if (host.rsp_ready_i) next_state = IDLE;
            default:   next_state = IDLE;
        endcase
    end

    always_comb begin
        host.req_ready_o = (state == IDLE);
        busy_o           = (state != IDLE);
    end

    // Handshake outputs are registered from next_state so they line up with the state they mark.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            start_o          <= 1'b0;
            host.rsp_valid_o <= 1'b0;
            host.rsp_A_o4    <= 4'd0;
            host.rsp_E_o     <= 1'b0;
            host.rsp_tmo_o   <= 1'b0;
            count            <= '0;
        end else begin
            start_o          <= (next_state == START);
            host.rsp_valid_o <= (next_state == RESP);
            if (state == START) begin
                count <= '0;
            end else if (in_wait) begin
                count <= count + CW'(1);
            end
            if (capture) begin
                host.rsp_A_o4  <= A_i4;
                host.rsp_E_o   <= E_i;
                host.rsp_tmo_o <= !done_ok;
            end
        end
    end

endmodule

// File: tb/tb_design_exmpl_host_rtl.sv
// Directed bench for design_exmpl_host_rtl with a behavioural stand-in for the design example.
module tb_design_exmpl_host_rtl;

    logic       clk;
    logic       rst;
    logic       start;
    logic [3:0] A;
    logic       E;
    logic       F;
    logic       busy;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;
    int mode     = 0;   // 0 normal, 1 F stuck high, 2 F stuck low, 3 F rises on last budget cycle
    int cnt      = 0;

    design_exmpl_host_rtl_if h ();

    design_exmpl_host_rtl #(.TIMEOUT_CYCLES(32)) dut (
        .clk_i   (clk),
        .rst_i   (rst),
        .host    (h),
        .start_o (start),
        .A_i4    (A),
        .E_i     (E),
        .F_i     (F),
        .busy_o  (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Stand-in example: F clears on start, rises 14 cycles after start (32 in mode 3).
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            F <= 1'b0; A <= 4'd0; E <= 1'b0; cnt <= 0;
        end else if (mode == 1) begin
            F <= 1'b1; A <= 4'd6; E <= 1'b0;
        end else if (mode == 2) begin
            F <= 1'b0; A <= 4'd5; E <= 1'b0;
        end else if (start) begin
            F <= 1'b0; A <= 4'd0; E <= 1'b0; cnt <= 1;
        end else if (cnt != 0) begin
            if (cnt == ((mode == 3) ? 31 : 13)) begin
                F <= 1'b1; A <= 4'd13; E <= 1'b1; cnt <= 0;
            end else begin
                cnt <= cnt + 1;
            end
        end
    end

    task automatic wait_start(output bit seen);
        seen = 1'b0;
        for (int i = 0; i < 64; i++) begin
            @(negedge clk);
            if (start) begin
                seen = 1'b1;
                return;
            end
        end
    endtask

    task automatic wait_rsp(output bit seen);
        seen = 1'b0;
        for (int i = 0; i < 64; i++) begin
            @(negedge clk);
            if (h.rsp_valid_o) begin
                seen = 1'b1;
                return;
            end
        end
    endtask

    task automatic test_reset;
        rst = 1'b1;
        @(negedge clk);
        checks++;
        if ({start, h.rsp_valid_o, h.rsp_A_o4, h.rsp_E_o, h.rsp_tmo_o} !== 8'd0) begin
            failures++;
            $display("FAIL reset_outputs got=%b want=00000000",
                     {start, h.rsp_valid_o, h.rsp_A_o4, h.rsp_E_o, h.rsp_tmo_o});
        end
        rst = 1'b0;
        @(negedge clk);
        checks++;
        if ({h.req_ready_o, busy} !== 2'b10) begin
            failures++;
            $display("FAIL reset_ready_busy got=%b want=10", {h.req_ready_o, busy});
        end
    endtask

    task automatic test_single;
        bit ok;
        int n;
        mode = 0;
        h.rsp_ready_i = 1'b1;
        h.req_valid_i = 1'b1;
        wait_start(ok);
        h.req_valid_i = 1'b0;
        n = cyc;
        checks++;
        if (!ok) begin failures++; $display("FAIL single_start got=none want=pulse"); end
        @(negedge clk);
        checks++;
        if (start !== 1'b0) begin failures++; $display("FAIL single_pulse_width got=%b want=0", start); end
        wait_rsp(ok);
        checks++;
        if (!ok || (cyc - n) != 15) begin
            failures++;
            $display("FAIL single_latency got=%0d want=15 (seen=%0d)", cyc - n, ok);
        end
        checks++;
        if ({h.rsp_A_o4, h.rsp_E_o, h.rsp_tmo_o} !== 6'b1101_1_0) begin
            failures++;
            $display("FAIL single_payload got=%b want=110110", {h.rsp_A_o4, h.rsp_E_o, h.rsp_tmo_o});
        end
        @(negedge clk);
        checks++;
        if ({h.rsp_valid_o, h.req_ready_o} !== 2'b01) begin
            failures++;
            $display("FAIL single_return_idle got=%b want=01", {h.rsp_valid_o, h.req_ready_o});
        end
    endtask

    task automatic test_back_to_back;
        bit ok;
        int n;
        int r;
        mode = 0;
        h.rsp_ready_i = 1'b1;
        h.req_valid_i = 1'b1;
        wait_start(ok);
        n = cyc;
        wait_rsp(ok);
        r = cyc;
        checks++;
        if (!ok || (r - n) != 15 || h.req_ready_o !== 1'b0 ||
            {h.rsp_A_o4, h.rsp_E_o, h.rsp_tmo_o} !== 6'b1101_1_0) begin
            failures++;
            $display("FAIL b2b_first got=lat%0d rdy%b pl%b want=lat15 rdy0 pl110110",
                     r - n, h.req_ready_o, {h.rsp_A_o4, h.rsp_E_o, h.rsp_tmo_o});
        end
        @(negedge clk);
        checks++;
        if ({h.req_ready_o, start} !== 2'b10) begin
            failures++;
            $display("FAIL b2b_gap got=%b want=10", {h.req_ready_o, start});
        end
        wait_start(ok);
        h.req_valid_i = 1'b0;
        n = cyc;
        checks++;
        if (!ok || (n - r) != 2) begin
            failures++;
            $display("FAIL b2b_second_accept got=%0d want=2", n - r);
        end
        wait_rsp(ok);
        checks++;
        if (!ok || (cyc - n) != 15 || {h.rsp_A_o4, h.rsp_E_o, h.rsp_tmo_o} !== 6'b1101_1_0) begin
            failures++;
            $display("FAIL b2b_second got=lat%0d pl%b want=lat15 pl110110",
                     cyc - n, {h.rsp_A_o4, h.rsp_E_o, h.rsp_tmo_o});
        end
        @(negedge clk);
    endtask

    task automatic test_stuck(input int m, input logic [3:0] exp_a);
        bit ok;
        int n;
        mode = m;
        h.rsp_ready_i = 1'b1;
        @(negedge clk);
        h.req_valid_i = 1'b1;
        wait_start(ok);
        h.req_valid_i = 1'b0;
        n = cyc;
        wait_rsp(ok);
        checks++;
        if (!ok || (cyc - n) != 33 || {h.rsp_A_o4, h.rsp_E_o, h.rsp_tmo_o} !== {exp_a, 2'b01}) begin
            failures++;
            $display("FAIL stuck_mode%0d got=lat%0d pl%b want=lat33 pl%b",
                     m, cyc - n, {h.rsp_A_o4, h.rsp_E_o, h.rsp_tmo_o}, {exp_a, 2'b01});
        end
        @(negedge clk);
        mode = 0;
    endtask

    task automatic test_backpressure;
        bit ok;
        mode = 0;
        h.rsp_ready_i = 1'b0;
        h.req_valid_i = 1'b1;
        wait_start(ok);
        h.req_valid_i = 1'b0;
        wait_rsp(ok);
        checks++;
        if (!ok) begin failures++; $display("FAIL bp_rsp got=none want=valid"); end
        for (int i = 1; i <= 5; i++) begin
            @(negedge clk);
            checks++;
            if ({h.rsp_valid_o, h.req_ready_o, h.rsp_A_o4, h.rsp_E_o, h.rsp_tmo_o} !== 8'b10_1101_10) begin
                failures++;
                $display("FAIL bp_hold_%0d got=%b want=10110110", i,
                         {h.rsp_valid_o, h.req_ready_o, h.rsp_A_o4, h.rsp_E_o, h.rsp_tmo_o});
            end
        end
        h.rsp_ready_i = 1'b1;
        @(negedge clk);
        checks++;
        if ({h.rsp_valid_o, h.req_ready_o, busy} !== 3'b010) begin
            failures++;
            $display("FAIL bp_release got=%b want=010", {h.rsp_valid_o, h.req_ready_o, busy});
        end
    endtask

    task automatic test_boundary;
        bit ok;
        int n;
        mode = 3;
        h.rsp_ready_i = 1'b1;
        h.req_valid_i = 1'b1;
        wait_start(ok);
        h.req_valid_i = 1'b0;
        n = cyc;
        wait_rsp(ok);
        checks++;
        if (!ok || (cyc - n) != 33 || {h.rsp_A_o4, h.rsp_E_o, h.rsp_tmo_o} !== 6'b1101_1_0) begin
            failures++;
            $display("FAIL boundary_last_cycle got=lat%0d pl%b want=lat33 pl110110",
                     cyc - n, {h.rsp_A_o4, h.rsp_E_o, h.rsp_tmo_o});
        end
        @(negedge clk);
        mode = 0;
    endtask

    task automatic test_reset_midrun;
        bit ok;
        bit replay;
        int n;
        mode = 0;
        h.rsp_ready_i = 1'b1;
        h.req_valid_i = 1'b1;
        wait_start(ok);
        h.req_valid_i = 1'b0;
        n = cyc;
        while (cyc < n + 5) @(negedge clk);
        rst = 1'b1;
        #1;
        checks++;
        if ({busy, h.req_ready_o, start, h.rsp_valid_o, h.rsp_A_o4, h.rsp_E_o, h.rsp_tmo_o} !== 10'b01_0000_0000) begin
            failures++;
            $display("FAIL midrun_reset got=%b want=0100000000",
                     {busy, h.req_ready_o, start, h.rsp_valid_o, h.rsp_A_o4, h.rsp_E_o, h.rsp_tmo_o});
        end
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        replay = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (h.rsp_valid_o || busy) replay = 1'b1;
        end
        checks++;
        if (replay) begin failures++; $display("FAIL midrun_no_replay got=activity want=idle"); end
        h.req_valid_i = 1'b1;
        wait_start(ok);
        h.req_valid_i = 1'b0;
        n = cyc;
        wait_rsp(ok);
        checks++;
        if (!ok || (cyc - n) != 15 || {h.rsp_A_o4, h.rsp_E_o, h.rsp_tmo_o} !== 6'b1101_1_0) begin
            failures++;
            $display("FAIL midrun_fresh_run got=lat%0d pl%b want=lat15 pl110110",
                     cyc - n, {h.rsp_A_o4, h.rsp_E_o, h.rsp_tmo_o});
        end
        @(negedge clk);
    endtask

    initial begin
        rst = 1'b1;
        h.req_valid_i = 1'b0;
        h.rsp_ready_i = 1'b1;
        test_reset();
        test_single();
        test_back_to_back();
        test_stuck(1, 4'd6);
        test_stuck(2, 4'd5);
        test_backpressure();
        test_boundary();
        test_reset_midrun();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
